// File: rtl/i2c_mux_arbiter_pkg.sv
// Shared types and constants for the I2C mux arbiter: FSM states and the
// TCA9544A-style control byte encoding.
package i2c_mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SWITCH,
    GRANTED,
    DRAIN
  } arb_state_e;

  localparam int unsigned PORT_W     = 2;
  localparam int unsigned MUX_EN_BIT = 2;
  localparam logic [7:0]  MUX_OFF    = 8'h00;

  // Control byte: enable bit plus the 2-bit downstream channel number.
  function automatic logic [7:0] mux_byte(input logic [PORT_W-1:0] port);
    logic [7:0] b;
    b             = MUX_OFF;
    b[MUX_EN_BIT] = 1'b1;
    b[PORT_W-1:0] = port;
    return b;
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// Upstream I2C bus observer: synchronizes SCL/SDA, tracks START/STOP into
// busy, and measures how long the bus has been idle.
module i2c_bus_monitor #(
  parameter int unsigned IDLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  input  logic sda_i,
  output logic busy,
  output logic bus_idle_c
);

  localparam int unsigned CNT_W = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

  logic [1:0]       scl_sync;
  logic [1:0]       sda_sync;
  logic             sda_q;
  logic [CNT_W-1:0] idle_cnt;
  logic             scl;
  logic             sda;
  logic             start_c;
  logic             stop_c;

  assign scl     = scl_sync[1];
  assign sda     = sda_sync[1];
  assign start_c = scl & sda_q & ~sda;
  assign stop_c  = scl & ~sda_q & sda;

  // Synchronizers reset high so an idle bus does not look like a START.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      sda_q    <= 1'b1;
      busy     <= 1'b0;
      idle_cnt <= '0;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
      sda_q    <= sda;
      if (start_c) begin
        busy <= 1'b1;
      end else if (stop_c) begin
        busy <= 1'b0;
      end
      if (!busy && scl && sda) begin
        if (idle_cnt < CNT_W'(IDLE_CYCLES)) begin
          idle_cnt <= idle_cnt + CNT_W'(1);
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  assign bus_idle_c = (idle_cnt >= CNT_W'(IDLE_CYCLES));

endmodule

// File: rtl/i2c_mux_arbiter.sv
// Round-robin arbiter granting local masters access to one downstream port of
// an I2C mux. Define I2C_MUX_ARBITER_TIMEOUT_EN to enable the grant watchdog.
// The release pulse input is named rel because release is a reserved word.
module i2c_mux_arbiter
  import i2c_mux_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned IDLE_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65536
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [2*N_REQ-1:0]    req_port,
  input  logic [N_REQ-1:0]      rel,
  output logic [N_REQ-1:0]      grant,
  output logic [7:0]            mux_sel,
  output logic                  busy,
  output logic                  timeout,
  input  logic                  scl_i,
  input  logic                  sda_i
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned SET_W = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;

  arb_state_e        state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [7:0]        mux_sel_q, mux_sel_d;
  logic [IDX_W-1:0]  win_q, win_d;
  logic [IDX_W-1:0]  last_q, last_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic              short_q, short_d;
  logic              bus_idle_c;
  logic              pick_vld_c;
  logic [IDX_W-1:0]  pick_c;
  logic [IDX_W-1:0]  cand_c;
  logic [PORT_W-1:0] port_a [N_REQ];

  i2c_bus_monitor #(
    .IDLE_CYCLES(IDLE_CYCLES)
  ) u_mon (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .busy      (busy),
    .bus_idle_c(bus_idle_c)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      port_a[i] = req_port[PORT_W*i +: PORT_W];
    end
  end

  // Scan farthest-to-nearest from last winner so the nearest request wins.
  always_comb begin
    pick_vld_c = 1'b0;
    pick_c     = '0;
    cand_c     = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand_c = IDX_W'((32'(last_q) + 32'(k)) % N_REQ);
      if (req[cand_c]) begin
        pick_vld_c = 1'b1;
        pick_c     = cand_c;
      end
    end
  end

`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            timeout_q, timeout_d;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    mux_sel_d = mux_sel_q;
    win_d     = win_q;
    last_d    = last_q;
    settle_d  = settle_q;
    short_d   = short_q;
`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
    wd_d      = wd_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (pick_vld_c && bus_idle_c) begin
          win_d     = pick_c;
          last_d    = pick_c;
          mux_sel_d = mux_byte(port_a[pick_c]);
          short_d   = (mux_sel_q == mux_byte(port_a[pick_c]));
          settle_d  = '0;
          state_d   = SWITCH;
        end
      end
      SWITCH: begin
        if (!req[win_q]) begin
          state_d = IDLE;
        end else if (short_q || settle_q == SET_W'(SETTLE_CYCLES)) begin
          grant_d        = '0;
          grant_d[win_q] = 1'b1;
          state_d        = GRANTED;
`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
          wd_d           = '0;
`endif
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      GRANTED: begin
        if (rel[win_q] || !req[win_q]) begin
          grant_d = '0;
          state_d = DRAIN;
        end
`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
        else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = DRAIN;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
`endif
      end
      DRAIN: begin
        if (bus_idle_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      mux_sel_q <= MUX_OFF;
      win_q     <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
      settle_q  <= '0;
      short_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      mux_sel_q <= mux_sel_d;
      win_q     <= win_d;
      last_q    <= last_d;
      settle_q  <= settle_d;
      short_q   <= short_d;
    end
  end

`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign grant   = grant_q;
  assign mux_sel = mux_sel_q;

endmodule

// File: tb/tb_i2c_mux_arbiter.sv
// Directed bench for i2c_mux_arbiter; covers the watchdog when
// I2C_MUX_ARBITER_TIMEOUT_EN is defined.
module tb_i2c_mux_arbiter;

`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
  localparam int unsigned TO_CYC = 100;
`else
  localparam int unsigned TO_CYC = 65536;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] req = '0;
  logic [7:0] req_port = '0;
  logic [3:0] rel = '0;
  logic [3:0] grant;
  logic [7:0] mux_sel;
  logic       busy;
  logic       timeout;
  logic       scl_i = 1'b1;
  logic       sda_i = 1'b1;

  int   checks = 0;
  int   failures = 0;
  logic oh_bad = 1'b0;
  logic to_seen = 1'b0;

  logic [3:0] exp_g [3] = '{4'b0010, 4'b1000, 4'b0001};
  logic [7:0] exp_s [3] = '{8'h06, 8'h05, 8'h04};

  always #5 clk = ~clk;

  i2c_mux_arbiter #(
    .N_REQ(4), .SETTLE_CYCLES(8), .IDLE_CYCLES(16), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_port(req_port), .rel(rel),
    .grant(grant), .mux_sel(mux_sel), .busy(busy), .timeout(timeout),
    .scl_i(scl_i), .sda_i(sda_i)
  );

  always @(negedge clk) begin
    if (!$onehot0(grant)) oh_bad <= 1'b1;
    if (timeout) to_seen <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int max, output int n);
    n = 0;
    while (grant == 4'b0 && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_sel(input logic [7:0] sel, input int max, output int n);
    n = 0;
    while (mux_sel != sel && n < max) begin
      tick();
      n++;
    end
  endtask

  task automatic drop(input logic [3:0] bits);
    rel = bits;
    req = req & ~bits;
    tick();
    rel = '0;
  endtask

  initial begin
    int n;
    repeat (3) tick();
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_mux", 32'(mux_sel), 32'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_timeout", 32'(timeout), 32'h0);

    // Single request after reset: 16 idle cycles, then 9-cycle settle.
    rst = 1'b1;
    req_port[3:2] = 2'd2;
    req[1] = 1'b1;
    wait_sel(8'h06, 40, n);
    chk("idle_lat", 32'(n), 32'd17);
    chk("sel_single", 32'(mux_sel), 32'h06);
    wait_grant(20, n);
    chk("settle_lat", 32'(n), 32'd9);
    chk("grant_single", 32'(grant), 32'b0010);
    drop(4'b0010);
    chk("released", 32'(grant), 32'h0);
    repeat (3) tick();

    // Make requester 0 the last winner.
    req_port[1:0] = 2'd0;
    req[0] = 1'b1;
    wait_grant(40, n);
    chk("grant_r0", 32'(grant), 32'b0001);
    drop(4'b0001);
    repeat (3) tick();

    // Contention: expect 1, 3, 0.
    req_port = 8'h48;
    req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      wait_grant(40, n);
      chk("rr_grant", 32'(grant), 32'(exp_g[i]));
      chk("rr_sel", 32'(mux_sel), 32'(exp_s[i]));
      if (i == 0) begin
        rel = 4'b1000;
        tick();
        rel = '0;
        chk("rel_ignored", 32'(grant), 32'b0010);
      end
      drop(exp_g[i]);
    end
    repeat (3) tick();

    // Requester withdraws during settle: no grant.
    req_port[5:4] = 2'd1;
    req = 4'b0100;
    wait_sel(8'h05, 10, n);
    chk("sel_withdraw", 32'(mux_sel), 32'h05);
    req = '0;
    repeat (15) tick();
    chk("withdraw_nogrant", 32'(grant), 32'h0);

    // Port change to 3, then same-port shortcut.
    req_port[7:6] = 2'd3;
    req = 4'b1000;
    wait_grant(30, n);
    chk("port_change_lat", 32'(n), 32'd10);
    chk("sel_p3", 32'(mux_sel), 32'h07);
    drop(4'b1000);
    repeat (3) tick();
    req_port[1:0] = 2'd3;
    req = 4'b0001;
    wait_grant(30, n);
    chk("shortcut_lat", 32'(n), 32'd2);
    chk("shortcut_grant", 32'(grant), 32'b0001);
    chk("shortcut_sel", 32'(mux_sel), 32'h07);
    drop(4'b0001);
    repeat (3) tick();

    // Foreign master: START, pending request, STOP.
    sda_i = 1'b0;
    repeat (2) tick();
    chk("busy_pre", 32'(busy), 32'h0);
    tick();
    chk("busy_start", 32'(busy), 32'h1);
    req_port[1:0] = 2'd0;
    req = 4'b0001;
    repeat (20) tick();
    chk("foreign_nogrant", 32'(grant), 32'h0);
    chk("foreign_sel_hold", 32'(mux_sel), 32'h07);
    sda_i = 1'b1;
    wait_grant(60, n);
    chk("foreign_lat", 32'(n), 32'd29);
    chk("busy_stop", 32'(busy), 32'h0);
    chk("foreign_sel", 32'(mux_sel), 32'h04);
    drop(4'b0001);
    repeat (3) tick();

`ifdef I2C_MUX_ARBITER_TIMEOUT_EN
    // Holder never releases; watchdog revokes, next requester served.
    req_port[3:2] = 2'd1;
    req_port[5:4] = 2'd2;
    req = 4'b0110;
    wait_grant(40, n);
    chk("wd_grant", 32'(grant), 32'b0010);
    n = 0;
    while (grant != 4'b0 && n < 200) begin
      tick();
      n++;
    end
    chk("wd_lat", 32'(n), 32'd100);
    chk("wd_pulse", 32'(timeout), 32'h1);
    tick();
    chk("wd_pulse_end", 32'(timeout), 32'h0);
    wait_grant(40, n);
    chk("wd_next", 32'(grant), 32'b0100);
    drop(4'b0110);
    repeat (3) tick();
`else
    // No watchdog: a long grant persists and timeout never pulses.
    req_port[3:2] = 2'd1;
    req = 4'b0010;
    wait_grant(40, n);
    chk("hold_grant", 32'(grant), 32'b0010);
    repeat (150) tick();
    chk("hold_persist", 32'(grant), 32'b0010);
    chk("no_timeout", 32'(to_seen), 32'h0);
    drop(4'b0010);
    repeat (3) tick();
`endif

    // Reset mid-grant clears outputs with no clock edge.
    req_port[5:4] = 2'd3;
    req = 4'b0100;
    wait_grant(40, n);
    chk("pre_rst_grant", 32'(grant), 32'b0100);
    #2;
    rst = 1'b0;
    #1;
    chk("async_grant", 32'(grant), 32'h0);
    chk("async_sel", 32'(mux_sel), 32'h00);
    repeat (2) tick();
    rst = 1'b1;
    wait_sel(8'h07, 40, n);
    chk("post_rst_idle_lat", 32'(n), 32'd17);
    drop(4'b0100);
    repeat (3) tick();

    chk("onehot0", 32'(oh_bad), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
